ff_bank: RTL

//  WIDTH-bit multi-mode flip-flop bank: a vector of edge-triggered storage bits.
//  Per-cycle mode selects D-load, T-toggle, JK, SR, shift left/right, sync clear or hold.

---
 rtl/ff_bank_if.sv | 19 +
 rtl/ff_bank.sv | 54 +++++
 2 files changed

// File: rtl/ff_bank_if.sv
// ff_bank_if: control, data and status bundle for the multi-mode flip-flop bank
interface ff_bank_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
);
  logic             en;
  logic [2:0]       mode;
  logic [WIDTH-1:0] d;
  logic [WIDTH-1:0] k;
  logic             sin;
  logic             cnt_clr;
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] qbar;
  logic             sout;
  logic             changed;
  logic [CNT_W-1:0] chg_cnt;
  modport master (output en, mode, d, k, sin, cnt_clr, input q, qbar, sout, changed, chg_cnt);
  modport slave (input en, mode, d, k, sin, cnt_clr, output q, qbar, sout, changed, chg_cnt);
endinterface

// File: rtl/ff_bank.sv
// ff_bank: multi-mode flip-flop bank with complement/serial outputs and a saturating change counter
module ff_bank #(
  parameter int               WIDTH     = 8,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter bit               SET_WINS  = 1'b0,
  parameter int               CNT_W     = 8
) (
  input logic     clk,
  input logic     rst_n,
  ff_bank_if.slave bus
);
  localparam logic [2:0] M_LOAD = 3'd1, M_TGL = 3'd2, M_JK = 3'd3, M_SR = 3'd4,
                         M_SHL = 3'd5, M_SHR = 3'd6, M_CLR = 3'd7;
  localparam logic [WIDTH-1:0] SW_MASK = SET_WINS ? '1 : '0;
  logic [WIDTH-1:0] r_q, r_qbar, w_qn;
  logic [CNT_W-1:0] r_cnt;
  logic             r_sout, r_changed, w_chg, w_shift, w_sbit;
  // next-state selection; JK and SR are expressed as per-bit boolean equations
  always_comb begin
    w_qn = bus.mode == M_LOAD ? bus.d :
           bus.mode == M_TGL  ? r_q ^ bus.d :
           bus.mode == M_JK   ? (bus.d & ~r_q) | (~bus.k & r_q) :
           bus.mode == M_SR   ? (bus.d & (~bus.k | SW_MASK)) | (~bus.d & ~bus.k & r_q) :
           bus.mode == M_SHL  ? {r_q[WIDTH-2:0], bus.sin} :
           bus.mode == M_SHR  ? {bus.sin, r_q[WIDTH-1:1]} :
           bus.mode == M_CLR  ? RESET_VAL : r_q;
    w_chg   = w_qn != r_q;
    w_shift = bus.mode == M_SHL || bus.mode == M_SHR;
    w_sbit  = bus.mode == M_SHL ? r_q[WIDTH-1] : r_q[0];
  end
  // qbar is its own register so it switches on the same edge as q
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_q       <= RESET_VAL;
      r_qbar    <= ~RESET_VAL;
      r_sout    <= 1'b0;
      r_changed <= 1'b0;
      r_cnt     <= '0;
    end else begin
      if (bus.en) begin
        r_q    <= w_qn;
        r_qbar <= ~w_qn;
      end
      if (bus.en && w_shift) r_sout <= w_sbit;
      r_changed <= bus.en && w_chg;
      r_cnt     <= bus.cnt_clr ? '0 : (bus.en && w_chg && r_cnt != '1) ? r_cnt + 1'b1 : r_cnt;
    end
  end
  assign bus.q       = r_q;
  assign bus.qbar    = r_qbar;
  assign bus.sout    = r_sout;
  assign bus.changed = r_changed;
  assign bus.chg_cnt = r_cnt;
endmodule
